// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions for the arithmetic library
// (multiplier and divider use the same numeric model: truncation, no denormals).
package fp_pkg;

    localparam int              FP_EXP_W   = 8;
    localparam int              FP_FRAC_W  = 23;
    localparam int              FP_BIAS    = 127;
    localparam logic [31:0]     FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]      FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
    } fp32_t;

    // Divider control states; also exported on the interface for observation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fdiv_state_t;

    // True when the magnitude (everything below the sign bit) is zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x.e == 8'd0) && (x.f == 23'd0);
    endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid && ready; the sender holds data and valid stable until that edge,
// and valid never waits on ready.
interface fdiv_seq_if #(parameter int W = 32);
    import fp_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         div_by_zero;
    logic         overflow;
    logic         underflow;
    fdiv_state_t  state;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, z, div_by_zero, overflow, underflow, state
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, z, div_by_zero, overflow, underflow, state
    );

endinterface

// File: rtl/fdiv_seq_mant_div.sv
// Restoring mantissa divider: one quotient bit per clock for FRAC_W+2 clocks.
// Quotient Q has its MSB at weight 2^0, so Q lies in (0.5, 2).
module mant_div_restoring #(
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [FRAC_W-1:0] fa_i,
    input  logic [FRAC_W-1:0] fb_i,
    output logic              done_o,
    output logic [FRAC_W+1:0] q_o
);
    localparam int RW = FRAC_W + 2;
    localparam int CW = $clog2(FRAC_W + 2);

    logic [RW-1:0]   r_q;
    logic [FRAC_W:0] d_q;
    logic [RW-1:0]   q_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    logic            ge;
    logic [RW-1:0]   diff;

    assign ge   = (r_q >= {1'b0, d_q});
    assign diff = r_q - {1'b0, d_q};

    // Load operands on start, then subtract-or-shift once per clock; done pulses after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            r_q    <= {2'b01, fa_i};
            d_q    <= {1'b1, fb_i};
            q_q    <= '0;
            cnt_q  <= CW'(FRAC_W + 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            // Remainder after a subtract is below D, so the dropped top bit is always zero.
            r_q <= ge ? {diff[RW-2:0], 1'b0} : {r_q[RW-2:0], 1'b0};
            q_q <= {q_q[RW-2:0], ge};
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o = done_q;
    assign q_o    = q_q;

endmodule

// File: rtl/fdiv_seq.sv
// Iterative single-precision divider z = a / b with valid/ready handshakes.
// Truncating, no denormals; zero operands are handled at accept time.
module fdiv_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    fdiv_seq_if.slave  bus
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int QW = FRAC_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_S  = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S  = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S  = EW'(0);

    fdiv_state_t state_q, state_d;

    logic             sign_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [W-1:0]     z_q, z_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             accept;
    logic             sign_in;
    logic             a_zero, b_zero;
    logic             div_start;
    logic             div_done;
    logic [QW-1:0]    q;

    logic signed [EW-1:0] e_raw, e_adj;
    logic [FRAC_W-1:0]    frac_n;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign sign_in = bus.a[W-1] ^ bus.b[W-1];
    assign a_zero  = fp_is_zero(fp32_t'(bus.a));
    assign b_zero  = fp_is_zero(fp32_t'(bus.b));

    mant_div_restoring #(.FRAC_W(FRAC_W)) u_mant (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .fa_i    (bus.a[FRAC_W-1:0]),
        .fb_i    (bus.b[FRAC_W-1:0]),
        .done_o  (div_done),
        .q_o     (q)
    );

    // Capture result sign and both exponents when operands are accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
        end else if (accept) begin
            sign_q <= sign_in;
            ea_q   <= bus.a[W-2:FRAC_W];
            eb_q   <= bus.b[W-2:FRAC_W];
        end
    end

    // Normalise the quotient: shift left by one when it fell below 1.0.
    always_comb begin
        e_raw  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_S;
        e_adj  = e_raw;
        frac_n = q[QW-2:1];
        if (!q[QW-1]) begin
            frac_n = q[QW-3:0];
            e_adj  = e_raw - ONE_S;
        end
    end

    // Control FSM next state plus result/flag updates.
    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (b_zero) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        z_d     = a_zero ? FP_QNAN : {sign_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    end else if (a_zero) begin
                        state_d = DONE;
                        z_d     = {sign_in, {(W-1){1'b0}}};
                    end else begin
                        state_d   = DIV;
                        div_start = 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done) state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (e_adj >= EMAX_S) begin
                    z_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_d = 1'b1;
                end else if (e_adj <= ZERO_S) begin
                    z_d   = {sign_q, {(W-1){1'b0}}};
                    unf_d = 1'b1;
                end else begin
                    z_d = {sign_q, e_adj[EXP_W-1:0], frac_n};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            z_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.z           = z_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: hand-computed quotients, special cases,
// back-pressure hold and mid-operation reset.
module tb_fdiv_seq;
    import fp_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   acc_cyc = 0;

    logic [31:0] exp_q[$];
    logic [2:0]  exp_fq[$];

    fdiv_seq_if bus ();

    fdiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock, cycle counter and global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.div_by_zero, bus.overflow, bus.underflow};
    endfunction

    // Present operands from a negedge and hold them until accepted; returns
    // at the negedge right after the accept edge with in_valid dropped.
    task automatic send(input logic [31:0] av, input logic [31:0] bv);
        int g;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        g = 0;
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        acc_cyc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare against the scoreboard, optionally hold
    // out_ready low while offering a competing operand, then complete the handshake.
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int g;
        logic [31:0] ez;
        logic [2:0]  ef;
        g = 0;
        while (!bus.out_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        ez = exp_q.pop_front();
        ef = exp_fq.pop_front();
        check({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(exp_lat));
        check({tag, "_z"}, bus.z, ez);
        check({tag, "_flags"}, 32'(flags()), 32'(ef));
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.a = 32'h3F800000;
            bus.b = 32'h00000000;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_z"}, bus.z, ez);
                check({tag, "_hold_flags"}, 32'(flags()), 32'(ef));
                check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
                check({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_z_held"}, bus.z, ez);
        check({tag, "_post_flags"}, 32'(flags()), 32'd0);
    endtask

    // Flags are packed as {div_by_zero, overflow, underflow}. Latency counts
    // rising edges after the accept edge until out_valid is seen: the iterative
    // path takes 27, zero operands finish in the cycle right after the accept edge.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ez, input logic [2:0] ef, input int exp_lat,
                          input int hold);
        exp_q.push_back(ez);
        exp_fq.push_back(ef);
        send(av, bv);
        collect(tag, exp_lat, hold);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_z", bus.z, 32'h0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Normal quotients (6/2, 1/3 truncated, -1.5/0.5).
        run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27, 0);
        run_op("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 27, 0);
        run_op("neg_div",    32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000, 27, 0);

        // Zero operands; 0/0 forces a positive quiet NaN even with a negative zero.
        run_op("x_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 0, 0);
        run_op("zero_zero",  32'h80000000, 32'h00000000, 32'h7FC00000, 3'b100, 0, 0);
        run_op("zero_by_x",  32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 0, 0);

        // Exponent range limits.
        run_op("overflow",   32'h7F000000, 32'h00800000, 32'h7F800000, 3'b010, 27, 0);
        run_op("underflow",  32'h00800000, 32'h7F000000, 32'h00000000, 3'b001, 27, 0);

        // Back-pressure: result held for 10 cycles, competing operands ignored.
        run_op("hold", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27, 10);

        // Abort during the 12th DIV cycle.
        send(32'h40C00000, 32'h40000000);
        repeat (11) @(negedge clk);
        check("abort_in_div", 32'(bus.state), 32'(DIV));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_z", bus.z, 32'h0);
        check("abort_flags", 32'(flags()), 32'd0);
        check("abort_state", 32'(bus.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_output", 32'(bus.out_valid), 32'd0);
        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Iterative single-precision floating-point divider; computes z = a / b. It is the inverse-direction companion to the combinational floating-point multiplier in the FPGA arithmetic library.
- Mantissa uses a restoring divider producing one quotient bit per cycle.
- Operands enter and results leave through valid/ready handshakes, so the block drops into the same datapaths as the multiplier behind a register stage.
- Rounding is truncation, with no denormal support, matching the multiplier's numeric model.

Parameters:
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1.
- FRAC_W, 23, stored fraction width. Only the 8/23 configuration is verified.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a and b are valid
- in_ready  out  1  block can accept operands
- a  in  1+EXP_W+FRAC_W  dividend, IEEE-754 layout {sign, exp, frac}
- b  in  1+EXP_W+FRAC_W  divisor, same layout
- out_valid  out  1  z and flags are valid
- out_ready  in  1  consumer accepts the result
- z  out  1+EXP_W+FRAC_W  quotient
- div_by_zero  out  1  b was zero (includes 0/0)
- overflow  out  1  result saturated to infinity
- underflow  out  1  result flushed to zero

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, z = 0, all flags = 0, internal registers = 0.
- States: IDLE, DIV, NORM, DONE.
- in_ready = (state == IDLE). Accept occurs when in_valid && in_ready at a rising edge.
- On accept, latch:
  - sign = a.s ^ b.s
  - ea, eb
  - dividend register R = {1, fa}
  - divisor register D = {1, fb}
  - quotient Q = 0
  - iteration counter = FRAC_W+1
- Special cases, checked on accept on the magnitude field (bits below the sign):
  - b == 0 and a != 0: z = {sign, all-ones exp, 0}, div_by_zero = 1.
  - a == 0 and b == 0: z = 32'h7FC00000 (quiet NaN, sign forced to 0), div_by_zero = 1.
  - a == 0 and b != 0: z = {sign, 0}, no flags set.
  - In all special cases, go directly to DONE; out_valid rises one cycle after accept.
- Exponent 0 with a nonzero fraction is treated as a normal number with hidden bit 1. Exponent all-ones inputs are not special-cased.
- DIV state, one cycle per quotient bit, FRAC_W+2 cycles total (25 by default):
  - If R >= D: R = (R - D) << 1 and shift 1 into Q; otherwise R = R << 1 and shift 0 into Q.
  - Width of R is FRAC_W+2 bits.
  - Go to NORM after the last bit.
- NORM state, one cycle. Compute exponent E = ea - eb + bias in a signed EXP_W+2-bit adder:
  - If Q[MSB] = 1 (quotient in [1,2)): frac = Q[MSB-1:1].
  - Otherwise (quotient in [0.5,1)): frac = Q[MSB-2:0], and E = E - 1.
  - If E >= 2^EXP_W-1: z = {sign, all-ones exp, 0}, overflow = 1.
  - If E <= 0: z = {sign, 0}, underflow = 1.
  - Otherwise z = {sign, E[EXP_W-1:0], frac}.
  - Go to DONE.
- Latency, normal path: out_valid is high 27 clock edges after the accept edge (1 setup + 25 DIV + 1 NORM).
- DONE state:
  - out_valid = 1; z and flags are held stable while out_ready = 0.
  - On out_valid && out_ready: out_valid = 0, flags cleared, go to IDLE. z holds its last value.
  - in_ready rises the cycle after the handshake, so there is no same-cycle accept and no overlap.
- Asserting rst_n low mid-operation aborts immediately; the block returns to IDLE with reset values and produces no partial output.
- in_valid and operands arriving while busy are ignored; the producer must hold them until in_ready.

Decomposition:
- Package fp_pkg, shared with the multiplier:
  - typedef fp32_t as a packed struct {s, e[7:0], f[22:0]}
  - constants FP_BIAS = 127, FP_QNAN = 32'h7FC00000, FP_EXP_MAX = 8'hFF
  - function fp_is_zero(fp32_t), true when the magnitude field is zero
  - state enum fdiv_state_t
- One natural sub-module: mant_div_restoring. It holds the R/D/Q registers and counter, has start/done, and produces Q. The top level handles the FSM control, the special cases and normalisation.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> z = 0x40400000, flags 0, out_valid exactly 27 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> z = 0x3EAAAAAA (truncated). 0xBFC00000 / 0x3F000000 -> z = 0xC0400000.
- 0x3F800000 / 0x00000000 -> z = 0x7F800000, div_by_zero = 1, one cycle latency. 0/0 -> 0x7FC00000, div_by_zero = 1. 0x80000000 / 0x3F800000 -> 0x80000000.
- 0x7F000000 / 0x00800000 -> z = 0x7F800000, overflow = 1. 0x00800000 / 0x7F000000 -> z = 0x00000000, underflow = 1.
- Hold out_ready = 0 for 10 cycles after out_valid -> z and flags stable, in_ready = 0, new in_valid ignored. Release -> in_ready = 1 on the next cycle.
- Assert rst_n low at DIV cycle 12 -> outputs at reset values immediately. Next operation 6.0/2.0 -> 0x40400000 with normal latency.
